regfile: RTL
============

# regfile

General-purpose register file for the five-stage OpenMIPS pipeline: 32 × 32-bit registers, written by the write-back end of the EX→MEM→WB result path (`we`/`waddr`/`wdata`) and read by ID through two combinational read ports. It also has a sequential dump engine that streams all 32 registers over a valid/ready handshake, for debug and trace capture, without stalling the pipeline.

## Interface
Parameters:
- none. Widths are fixed: data 32 bits (`RegBus`), address 5 bits (`RegAddrBus`).

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — reset, asynchronous, active-high (`RstEnable` = 1).
- `we`  in  1  — write enable from WB.
- `waddr`  in  5  — write register index.
- `wdata`  in  32  — write data.
- `re1`  in  1  — read port 1 enable.
- `raddr1`  in  5  — read port 1 index.
- `rdata1`  out  32  — read port 1 data (combinational).
- `re2`  in  1  — read port 2 enable.
- `raddr2`  in  5  — read port 2 index.
- `rdata2`  out  32  — read port 2 data (combinational).
- `dump_req`  in  1  — start a full-register dump (level, sampled in IDLE).
- `dump_ready`  in  1  — consumer accepts the current dump beat.
- `dump_valid`  out  1  — dump beat valid.
- `dump_addr`  out  5  — index of the current beat.
- `dump_data`  out  32  — register value for the current beat.
- `dump_busy`  out  1  — dump in progress (SCAN state).
- `dump_done`  out  1  — one-cycle pulse after the last beat is accepted.

## Operation
- Storage is `regs[0..31]`. `regs[0]` reads as 0 at all times, and writes to index 0 are dropped.
- Write: at the rising edge of `clk`, if `we`=1 and `waddr`≠0, then `regs[waddr]` ← `wdata`.
- Read port n (n = 1, 2): `rdata_n` = 0 in any of these cases: `rst`=1, `re_n`=0, or `raddr_n`=0. Otherwise it is the bypass value (see Configuration) or `regs[raddr_n]`.
- Both read ports are independent. They may address the same register, and both may match the write address.
- Dump FSM:
  - States: IDLE, SCAN, DONE.
  - IDLE → SCAN when `dump_req`=1. On that edge, idx←0 and `dump_data`←0 (register 0).
  - SCAN: `dump_valid`=1 and `dump_busy`=1; `dump_addr` shows idx.
  - In SCAN, on `dump_valid`&&`dump_ready`:
    - If idx<31: idx←idx+1 and `dump_data` ← value of regs[idx+1], including a same-edge write to idx+1 (new value wins).
    - If idx=31: go to DONE.
  - In SCAN with `dump_ready`=0: `dump_addr` and `dump_data` hold. They form a snapshot, so a later write to that index does not change the held beat.
  - DONE → IDLE unconditionally; `dump_done`=1 for exactly that cycle.
  - `dump_req` is ignored in SCAN and DONE. If `dump_req` is still high in IDLE, a new dump starts.
- The dump never blocks writes or reads.

## Timing
- Reads have zero latency (combinational from address, enable, storage and, when compiled in, the write port).
- A write is visible in storage from the cycle after its edge.
- First dump beat is valid 1 cycle after `dump_req` is sampled. The minimum dump length is 32 SCAN cycles plus 1 DONE cycle.
- Reset (asynchronous, immediate, also mid-dump):
  - All `regs` ← 0.
  - FSM → IDLE, idx←0.
  - `dump_valid`, `dump_busy`, `dump_done` = 0; `dump_addr` = 0; `dump_data` = 0.
  - `rdata1` and `rdata2` = 0.
  - An interrupted dump is discarded; there is no `dump_done` for it.
- Simultaneous events:
  - A write to a register and a read of it in the same cycle follows the Configuration rules.
  - A write to idx+1 on the same edge as a handshake delivers the new value.

## Configuration
- Macro `REGFILE_WR_BYPASS_EN`.
- Defined: a read port with `re_n`=1, `raddr_n`≠0, `we`=1 and `raddr_n`==`waddr` returns `wdata` in the same cycle (write-to-read forwarding, so ID sees WB results immediately).
- Undefined: read ports return `regs[raddr_n]` only, i.e. the old value during a same-cycle write. Upstream forwarding must cover that hazard.
- The dump path's same-edge forwarding to idx+1 is present in both builds.

## Test plan
- Reset, then write 0x12345678 to r5. The next cycle, `re1`=1 and `raddr1`=5 → `rdata1`=0x12345678. With `re1`=0 → 0.
- Write 0xFFFFFFFF to r0 → `rdata2` with `raddr2`=0 stays 0, and dump beat 0 = 0.
- Same-cycle `we`=1, `waddr`=7, `wdata`=0xA5A5A5A5 and `raddr1`=7:
  - With `REGFILE_WR_BYPASS_EN` → `rdata1`=0xA5A5A5A5.
  - Without it → old value (0 after reset).
- Preload rN=N×0x11 for N=1..31. Pulse `dump_req` with `dump_ready`=1 → 32 consecutive beats, addr 0..31 with data 0, 0x11…0x20F. Then `dump_done` pulses once, and `dump_busy` drops.
- Dump with `dump_ready` toggling 1-0-0-1:
  - Beats hold across the stalls.
  - A write to r3 while beat 3 is stalled does not alter the held beat.
  - A write to r4 on the edge that accepts beat 3 shows the new value in beat 4.
- Assert `rst` at beat 10 of a dump → all outputs 0 immediately, no `dump_done`, all registers read 0. A fresh `dump_req` after reset restarts from addr 0.

Source files
------------

// File: rtl/regfile.sv
// regfile: 32 x 32-bit general-purpose register file for the OpenMIPS pipeline.
// Two combinational read ports, one write port, and a valid/ready dump engine
// that streams r0..r31 for debug/trace capture without stalling the pipeline.
// Optional build macro: REGFILE_WR_BYPASS_EN enables same-cycle write-to-read
// forwarding on both read ports.
module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        re1,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic        re2,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        dump_req,
    input  logic        dump_ready,
    output logic        dump_valid,
    output logic [4:0]  dump_addr,
    output logic [31:0] dump_data,
    output logic        dump_busy,
    output logic        dump_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] regs [0:31];
    logic [4:0]  nxt_addr;
    logic [31:0] nxt_data;

    // Register storage: writes to r0 are dropped so it always holds zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Read port 1: zero under reset, when disabled, or for r0
    always_comb begin
        rdata1 = '0;
        if (!rst && re1 && (raddr1 != 5'd0)) begin
`ifdef REGFILE_WR_BYPASS_EN
            if (we && (raddr1 == waddr)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs[raddr1];
            end
`else
            rdata1 = regs[raddr1];
`endif
        end
    end

    // Read port 2: same rules as port 1, fully independent
    always_comb begin
        rdata2 = '0;
        if (!rst && re2 && (raddr2 != 5'd0)) begin
`ifdef REGFILE_WR_BYPASS_EN
            if (we && (raddr2 == waddr)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs[raddr2];
            end
`else
            rdata2 = regs[raddr2];
`endif
        end
    end

    // Next dump beat: a write landing on the next index this edge wins over storage
    always_comb begin
        nxt_addr = dump_addr + 5'd1;
        if (we && (waddr == nxt_addr)) begin
            nxt_data = wdata;
        end else begin
            nxt_data = regs[nxt_addr];
        end
    end

    // Dump engine: dump_addr doubles as the scan index; data is a held snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_valid <= 1'b0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dump_done <= 1'b0;
                    if (dump_req) begin
                        state      <= SCAN;
                        dump_addr  <= '0;
                        dump_data  <= '0;
                        dump_valid <= 1'b1;
                        dump_busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (dump_ready) begin
                        if (dump_addr == 5'd31) begin
                            state      <= DONE;
                            dump_valid <= 1'b0;
                            dump_busy  <= 1'b0;
                            dump_done  <= 1'b1;
                        end else begin
                            dump_addr <= nxt_addr;
                            dump_data <= nxt_data;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    dump_done <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    dump_valid <= 1'b0;
                    dump_busy  <= 1'b0;
                    dump_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
